tie_lookup_ram_pipe: RTL and testbench
======================================

Name: tie_lookup_ram_pipe

Overview:
- Parametrised TIE lookup-RAM device that answers Xtensa core TIE lookup requests.
- Successor to the fixed 41-bit-request / 32-bit-response lookup RAM. Adds the following over it:
  - configurable address width, data width, depth and response latency;
  - write (swap) requests;
  - a ready handshake;
  - post-reset memory auto-clear;
  - out-of-range detection.
- Sits beside the core in the Testbench / system top. It connects directly to the core's TIE_<name>_Out_Req / _Out / _In / _Rdy lookup signals.

Parameters:
- ADDR_W, 8: address field width.
- DATA_W, 32: data width of write data and response.
- DEPTH, 256: number of words. Must satisfy 2 <= DEPTH <= 2**ADDR_W.
- LATENCY, 1: request-accept to response cycles. Legal range 1..4.
- OUT_W, 1+ADDR_W+DATA_W: request width, 41 at defaults. Derived; do not override.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- TIE_lookup_ram_Out_Req  in  1  request valid from core.
- TIE_lookup_ram_Out  in  OUT_W  request word. Fields:
  - [OUT_W-1] = wr;
  - [OUT_W-2:DATA_W] = addr;
  - [DATA_W-1:0] = wdata.
- TIE_lookup_ram_Rdy  out  1  device can accept a request this cycle.
- TIE_lookup_ram_In  out  DATA_W  response data to core.
- InitDone  out  1  auto-clear finished.
- AddrErr  out  1  sticky flag: an out-of-range request was accepted.

Behaviour:
- Reset (Reset_n=0 sampled at an edge):
  - Rdy=0, In=0, InitDone=0, AddrErr=0.
  - All pipeline valids cleared; clear counter=0.
  - Reset asserted mid-operation discards in-flight responses and restarts the clear.
- FSM states: CLEAR -> RUN.
  - CLEAR: writes 0 to word cnt each cycle; cnt increments by 1. When cnt == DEPTH-1 the state moves to RUN at the next edge. CLEAR therefore lasts exactly DEPTH cycles.
  - Rdy=0 throughout CLEAR.
  - RUN: Rdy=1 and InitDone=1 from the first RUN cycle until the next reset.
- Accept rule: a request is accepted on an edge where Out_Req=1 and Rdy=1. Out_Req while Rdy=0 is ignored; the core must hold it. At most one request is accepted per cycle.
- Read (wr=0): In shows mem[addr] exactly LATENCY cycles after the accept edge.
- Write/swap (wr=1):
  - mem[addr] <= wdata at the accept edge;
  - In returns the old contents after LATENCY cycles (read-before-write).
- Back-to-back ordering: a request accepted at edge N+1 sees the write accepted at edge N. There is no stale data for any LATENCY.
- Out-of-range (addr >= DEPTH):
  - a read returns 0;
  - a write is dropped;
  - AddrErr is set at the accept edge and stays set until reset.
  - The response still arrives at the normal LATENCY, so the pipeline timing is unchanged.
- In holds its last value in cycles with no response due. It updates only when a valid response leaves the final pipe stage.
- Fully pipelined: a new request every cycle gives a response every cycle, LATENCY cycles later.
- Widths: addr compare is unsigned, ADDR_W bits. There is no wrap-around on addr; out-of-range is an error, not a modulo.

Decomposition:
- Package tie_lookup_pkg holds:
  - field-offset constants/functions for wr/addr/wdata given ADDR_W and DATA_W;
  - the FSM state encoding (CLEAR, RUN);
  - the LATENCY legality check.
- One sub-module, tie_lookup_delay:
  - a {valid, DATA_W data} shift pipe of depth LATENCY-1 after the registered array read;
  - synchronous active-low clear of the valid bits.

Test Plan:
- Reset release, DEPTH=256 -> Rdy=0 for exactly 256 cycles, then Rdy=1 and InitDone=1. A read of addr 0xFF afterwards returns 0.
- LATENCY=1: write 0xDEADBEEF at addr 0x10, then read 0x10 on the next cycle. Expected:
  - write response = 0x00000000 one cycle after its accept;
  - read response = 0xDEADBEEF one cycle after its accept.
- LATENCY=3, streaming:
  - first write addr i <- i*3 for i=0..7;
  - then 8 back-to-back reads;
  - In shows 0,3,..,21 on consecutive cycles, starting 3 cycles after the first read accept.
- DEPTH=200, addr 0xC8:
  - write 0x55 -> AddrErr=1 and no write occurs;
  - read 0xC8 -> response 0;
  - AddrErr stays 1 across later legal accesses.
- Assert Reset_n=0 for one cycle with 2 reads in flight at LATENCY=4:
  - no further response updates; In=0;
  - Rdy=0 for DEPTH cycles; prior data read back as 0.
- Out_Req=1 during CLEAR with wr=1 addr 5 data 0x1234 -> request ignored; mem[5] reads 0 after InitDone.

Source files
------------

// File: rtl/tie_lookup_pkg.sv
// Shared definitions for the TIE lookup-RAM device.
//   - request word field positions derived from ADDR_W / DATA_W
//   - FSM state encoding (memory clear, then normal service)
//   - parameter legality checks used at elaboration
package tie_lookup_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } tie_state_e;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 4;

  // Request word layout: {wr, addr[ADDR_W-1:0], wdata[DATA_W-1:0]}
  function automatic int req_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  function automatic int wr_pos(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  function automatic int addr_msb(input int addr_w, input int data_w);
    return addr_w + data_w - 1;
  endfunction

  function automatic int addr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic bit latency_ok(input int lat);
    return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
  endfunction

  function automatic bit depth_ok(input int depth, input int addr_w);
    return (depth >= 2) && (longint'(depth) <= (longint'(1) << addr_w));
  endfunction

endpackage

// File: rtl/tie_lookup_delay.sv
// Response delay pipe for the TIE lookup RAM.
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low clear of the valid bits
//   vld_in   : response valid entering the pipe
//   data_in  : response data entering the pipe
//   vld_out  : valid leaving the last stage
//   data_out : data leaving the last stage
// STAGES may be zero, in which case the pipe is a straight wire.
module tie_lookup_delay #(
  parameter int DATA_W = 32,
  parameter int STAGES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              vld_out,
  output logic [DATA_W-1:0] data_out
);

  generate
    if (STAGES == 0) begin : g_pass
      // Clock and reset have no use when there are no stages.
      logic unused_ctl;
      assign unused_ctl = clk ^ rst_n;
      assign vld_out    = vld_in;
      assign data_out   = data_in;
    end else begin : g_pipe
      logic              vld_p  [STAGES];
      logic [DATA_W-1:0] data_p [STAGES];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < STAGES; i++) vld_p[i] <= 1'b0;
        end else begin
          vld_p[0] <= vld_in;
          for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
        end
      end

      always_ff @(posedge clk) begin
        data_p[0] <= data_in;
        for (int i = 1; i < STAGES; i++) data_p[i] <= data_p[i-1];
      end

      assign vld_out  = vld_p[STAGES-1];
      assign data_out = data_p[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/tie_lookup_ram_pipe.sv
// TIE lookup RAM answering Xtensa core lookup requests.
// After reset the memory is cleared one word per cycle (DEPTH cycles),
// then requests are accepted one per cycle whenever Rdy is high.
// Reads return mem[addr]; writes store wdata and return the old word.
// Responses appear LATENCY cycles after the accept edge.
//   CLK                    : clock, rising edge
//   Reset_n                : synchronous active-low reset
//   TIE_lookup_ram_Out_Req : request valid
//   TIE_lookup_ram_Out     : request word {wr, addr, wdata}
//   TIE_lookup_ram_Rdy     : request can be accepted this cycle
//   TIE_lookup_ram_In      : response data (holds between responses)
//   InitDone               : post-reset clear finished
//   AddrErr                : sticky, an out-of-range request was accepted
module tie_lookup_ram_pipe
  import tie_lookup_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1,
  parameter int OUT_W   = req_width(ADDR_W, DATA_W)
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              TIE_lookup_ram_Out_Req,
  input  logic [OUT_W-1:0]  TIE_lookup_ram_Out,
  output logic              TIE_lookup_ram_Rdy,
  output logic [DATA_W-1:0] TIE_lookup_ram_In,
  output logic              InitDone,
  output logic              AddrErr
);

  localparam int WR_POS   = wr_pos(ADDR_W, DATA_W);
  localparam int ADDR_MSB = addr_msb(ADDR_W, DATA_W);
  localparam int ADDR_LSB = addr_lsb(DATA_W);
  localparam int IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  generate
    if (!latency_ok(LATENCY)) begin : g_bad_latency
      $error("tie_lookup_ram_pipe: LATENCY must be in 1..4");
    end
    if (!depth_ok(DEPTH, ADDR_W)) begin : g_bad_depth
      $error("tie_lookup_ram_pipe: DEPTH must be in 2..2**ADDR_W");
    end
    if (OUT_W != req_width(ADDR_W, DATA_W)) begin : g_bad_out_w
      $error("tie_lookup_ram_pipe: OUT_W must equal 1+ADDR_W+DATA_W");
    end
  endgenerate

  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [IDX_W-1:0]  req_idx;
  logic              in_range;
  logic              accept;

  tie_state_e        state;
  tie_state_e        state_nxt;
  logic [IDX_W-1:0]  clr_cnt;
  logic              rdy;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;
  logic              vld_pn;
  logic [DATA_W-1:0] data_pn;

  assign req_wr    = TIE_lookup_ram_Out[WR_POS];
  assign req_addr  = TIE_lookup_ram_Out[ADDR_MSB:ADDR_LSB];
  assign req_wdata = TIE_lookup_ram_Out[DATA_W-1:0];
  assign req_idx   = req_addr[IDX_W-1:0];
  // Unsigned compare with one extra bit so DEPTH == 2**ADDR_W is representable.
  assign in_range  = ({1'b0, req_addr} < DEPTH_EXT);
  assign accept    = TIE_lookup_ram_Out_Req && rdy;

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + IDX_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    case (state)
      ST_CLEAR: if (clr_cnt == IDX_W'(DEPTH-1)) state_nxt = ST_RUN;
      ST_RUN:   rdy = 1'b1;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  assign TIE_lookup_ram_Rdy = rdy;
  assign InitDone           = rdy;

  // Clear has priority; no requests are accepted while clearing anyway.
  always_ff @(posedge CLK) begin
    if (Reset_n) begin
      if (state == ST_CLEAR) begin
        mem[clr_cnt] <= '0;
      end else if (accept && req_wr && in_range) begin
        mem[req_idx] <= req_wdata;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n)                  AddrErr <= 1'b0;
    else if (accept && !in_range)  AddrErr <= 1'b1;
  end

  // ---- stage p0: registered array read (old contents for a swap) ----
  always_ff @(posedge CLK) begin
    if (!Reset_n) vld_p0 <= 1'b0;
    else          vld_p0 <= accept;
  end

  always_ff @(posedge CLK) begin
    data_p0 <= in_range ? mem[req_idx] : '0;
  end

  // ---- stages p1..p(LATENCY-1): delay pipe ----
  tie_lookup_delay #(
    .DATA_W (DATA_W),
    .STAGES (LATENCY-1)
  ) u_delay (
    .clk      (CLK),
    .rst_n    (Reset_n),
    .vld_in   (vld_p0),
    .data_in  (data_p0),
    .vld_out  (vld_pn),
    .data_out (data_pn)
  );

  // ---- output stage: response register, holds between responses ----
  always_ff @(posedge CLK) begin
    if (!Reset_n)    TIE_lookup_ram_In <= '0;
    else if (vld_pn) TIE_lookup_ram_In <= data_pn;
  end

endmodule

// File: tb/tb_tie_lookup_ram_pipe.sv
module tb_tie_lookup_ram_pipe;

  localparam int NI = 3;
  localparam int DEP [NI] = '{256, 256, 200};
  localparam int LAT [NI] = '{1, 3, 4};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [40:0] out_w;

  logic        rdy_o  [NI];
  logic        done_o [NI];
  logic        err_o  [NI];
  logic [31:0] in_o   [NI];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state, one copy per instance.
  logic [31:0] mem_m [NI][256];
  int          clr_m [NI];
  bit          err_m [NI];
  logic [31:0] in_m  [NI];
  bit          pv_m  [NI][8];
  logic [31:0] pd_m  [NI][8];
  int          cyc;

  always #5 clk = ~clk;

  tie_lookup_ram_pipe #(.ADDR_W(8), .DATA_W(32), .DEPTH(256), .LATENCY(1)) u_l1 (
    .CLK(clk), .Reset_n(rst_n), .TIE_lookup_ram_Out_Req(req), .TIE_lookup_ram_Out(out_w),
    .TIE_lookup_ram_Rdy(rdy_o[0]), .TIE_lookup_ram_In(in_o[0]),
    .InitDone(done_o[0]), .AddrErr(err_o[0]));

  tie_lookup_ram_pipe #(.ADDR_W(8), .DATA_W(32), .DEPTH(256), .LATENCY(3)) u_l3 (
    .CLK(clk), .Reset_n(rst_n), .TIE_lookup_ram_Out_Req(req), .TIE_lookup_ram_Out(out_w),
    .TIE_lookup_ram_Rdy(rdy_o[1]), .TIE_lookup_ram_In(in_o[1]),
    .InitDone(done_o[1]), .AddrErr(err_o[1]));

  tie_lookup_ram_pipe #(.ADDR_W(8), .DATA_W(32), .DEPTH(200), .LATENCY(4)) u_d200 (
    .CLK(clk), .Reset_n(rst_n), .TIE_lookup_ram_Out_Req(req), .TIE_lookup_ram_Out(out_w),
    .TIE_lookup_ram_Rdy(rdy_o[2]), .TIE_lookup_ram_In(in_o[2]),
    .InitDone(done_o[2]), .AddrErr(err_o[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural model: after reset the device is blind for DEPTH edges,
  // then every request is served from a plain array and its answer is
  // scheduled for delivery LATENCY edges later.
  task automatic model_edge();
    logic [7:0]  a;
    logic [31:0] old;
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        clr_m[k] = DEP[k];
        err_m[k] = 1'b0;
        in_m[k]  = '0;
        for (int j = 0; j < 8; j++) pv_m[k][j] = 1'b0;
        for (int j = 0; j < 256; j++) mem_m[k][j] = '0;
      end else begin
        if (pv_m[k][cyc % 8]) begin
          in_m[k] = pd_m[k][cyc % 8];
          pv_m[k][cyc % 8] = 1'b0;
        end
        if (clr_m[k] > 0) begin
          clr_m[k]--;
        end else if (req) begin
          a = out_w[39:32];
          if (int'(a) < DEP[k]) begin
            old = mem_m[k][a];
            if (out_w[40]) mem_m[k][a] = out_w[31:0];
          end else begin
            old = '0;
            err_m[k] = 1'b1;
          end
          pv_m[k][(cyc + LAT[k]) % 8] = 1'b1;
          pd_m[k][(cyc + LAT[k]) % 8] = old;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s.i%0d.rdy", tag, k),  {31'd0, rdy_o[k]},  {31'd0, clr_m[k] == 0});
      chk($sformatf("%s.i%0d.done", tag, k), {31'd0, done_o[k]}, {31'd0, clr_m[k] == 0});
      chk($sformatf("%s.i%0d.err", tag, k),  {31'd0, err_o[k]},  {31'd0, err_m[k]});
      chk($sformatf("%s.i%0d.in", tag, k),   in_o[k],            in_m[k]);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic issue(input bit wr, input logic [7:0] a, input logic [31:0] d, input string tag);
    req   = 1'b1;
    out_w = {wr, a, d};
    step(tag);
    req   = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    req = 1'b0;
    repeat (n) step(tag);
  endtask

  task automatic wait_clear(input string tag, output int n0, output int n2);
    n0 = 0;
    n2 = -1;
    while (rdy_o[0] !== 1'b1 && n0 < 400) begin
      step(tag);
      n0++;
      if (rdy_o[2] === 1'b1 && n2 < 0) n2 = n0;
    end
  endtask

  initial begin
    #100_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n2;
    logic [7:0] ra;
    cyc   = 0;
    rst_n = 1'b0;
    req   = 1'b0;
    out_w = '0;
    for (int k = 0; k < NI; k++) clr_m[k] = DEP[k];

    // Reset state
    step("reset");
    step("reset");
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst.rdy%0d", k),  {31'd0, rdy_o[k]},  32'd0);
      chk($sformatf("rst.done%0d", k), {31'd0, done_o[k]}, 32'd0);
      chk($sformatf("rst.err%0d", k),  {31'd0, err_o[k]},  32'd0);
      chk($sformatf("rst.in%0d", k),   in_o[k],            32'd0);
    end

    // Clear phase with a write held on the bus for the first 100 cycles
    rst_n = 1'b1;
    n0 = 0;
    n2 = -1;
    while (rdy_o[0] !== 1'b1 && n0 < 400) begin
      if (n0 < 100) begin
        req   = 1'b1;
        out_w = {1'b1, 8'h05, 32'h0000_1234};
      end else begin
        req = 1'b0;
      end
      step("clear");
      n0++;
      if (rdy_o[2] === 1'b1 && n2 < 0) n2 = n0;
    end
    req = 1'b0;
    chk("clear_len_256", 32'(n0), 32'd256);
    chk("clear_len_200", 32'(n2), 32'd200);
    chk("initdone_256", {31'd0, done_o[0]}, 32'd1);

    // Cleared memory and the ignored write
    issue(1'b0, 8'hFF, 32'h0, "rd_ff");
    chk("rd_ff_l1", in_o[0], 32'h0);
    issue(1'b0, 8'h05, 32'h0, "rd_05");
    chk("rd_05_l1", in_o[0], 32'h0);
    idle(4, "drain0");
    chk("rd_05_l4", in_o[2], 32'h0);

    // Swap then read-after-write on the next cycle
    issue(1'b1, 8'h10, 32'hDEAD_BEEF, "wr_10");
    issue(1'b0, 8'h10, 32'h0, "rd_10");
    chk("swap_old_l1", in_o[0], 32'h0);
    idle(1, "rd_10_wait");
    chk("rd_10_l1", in_o[0], 32'hDEAD_BEEF);
    idle(4, "drain1");
    chk("rd_10_hold_l4", in_o[2], 32'hDEAD_BEEF);

    // Streaming writes then back-to-back reads
    for (int i = 0; i < 8; i++) issue(1'b1, 8'(i), 32'(i * 3), "stream_wr");
    for (int t = 0; t <= 10; t++) begin
      if (t < 8) issue(1'b0, 8'(t), 32'h0, "stream_rd");
      else       idle(1, "stream_rd");
      if (t >= 1 && t <= 8) chk($sformatf("stream_l1_t%0d", t), in_o[0], 32'((t - 1) * 3));
      if (t >= 3)           chk($sformatf("stream_l3_t%0d", t), in_o[1], 32'((t - 3) * 3));
      if (t >= 4)           chk($sformatf("stream_l4_t%0d", t), in_o[2], 32'((t - 4) * 3));
    end
    idle(2, "drain2");

    // Out-of-range for the 200-word instance only
    issue(1'b1, 8'hC8, 32'h0000_0055, "oor_wr");
    chk("oor_err_d200", {31'd0, err_o[2]}, 32'd1);
    chk("oor_err_d256", {31'd0, err_o[0]}, 32'd0);
    idle(4, "oor_gap");
    issue(1'b0, 8'hC8, 32'h0, "oor_rd");
    idle(4, "oor_rd_wait");
    chk("oor_rd_d200", in_o[2], 32'h0);
    chk("oor_rd_d256", in_o[0], 32'h0000_0055);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(192, 255)) : 8'($urandom_range(0, 15));
      req   = ($urandom_range(0, 3) != 0);
      out_w = {1'($urandom_range(0, 1)), ra, 32'($urandom)};
      step("rand");
    end
    req = 1'b0;
    idle(5, "drain3");
    chk("err_sticky_d200", {31'd0, err_o[2]}, 32'd1);

    // Reset with reads in flight
    issue(1'b1, 8'h20, 32'hCAFE_0001, "pre_rst_wr");
    idle(5, "pre_rst_gap");
    issue(1'b0, 8'h20, 32'h0, "inflight_a");
    issue(1'b0, 8'h21, 32'h0, "inflight_b");
    rst_n = 1'b0;
    step("mid_reset");
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("midrst.in%0d", k),  in_o[k],             32'h0);
      chk($sformatf("midrst.rdy%0d", k), {31'd0, rdy_o[k]},   32'd0);
      chk($sformatf("midrst.err%0d", k), {31'd0, err_o[k]},   32'd0);
    end
    rst_n = 1'b1;
    wait_clear("reclear", n0, n2);
    chk("reclear_len_256", 32'(n0), 32'd256);
    chk("reclear_len_200", 32'(n2), 32'd200);
    chk("reclear_in_l4", in_o[2], 32'h0);
    issue(1'b0, 8'h20, 32'h0, "post_rd_20");
    issue(1'b0, 8'h10, 32'h0, "post_rd_10");
    idle(4, "post_wait");
    chk("post_rd_10_l1", in_o[0], 32'h0);
    chk("post_rd_10_l4", in_o[2], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
